// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_counter
//  Description : Stopwatch core. Conditions three raw push-buttons
//                (synchronise, debounce, rising-edge event), runs the
//                IDLE/RUN/LAP/PAUSE control FSM and keeps a saturating 64-bit
//                elapsed-cycle count with a lap capture register.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter logic [63:0] MAX_COUNT       = 64'd2159999999999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_startstop,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [63:0] cnt,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1 before the level flips.
  localparam int unsigned    DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int BTN_SS  = 0;
  localparam int BTN_LAP = 1;
  localparam int BTN_CLR = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  logic [2:0] btn_raw;
  logic [2:0] evt;

  assign btn_raw = {btn_clear, btn_lap, btn_startstop};

  // --------------------------------------------------------------------------
  // Button conditioning: one identical channel per button
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic            sync_1;
    logic            sync_2;
    logic [DB_W-1:0] db_cnt;
    logic            level;
    logic            level_q;
    logic            evt_r;

    // Synchronise, require DEBOUNCE_CYCLES consecutive mismatches, then emit a 1-cycle rise pulse
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_1  <= 1'b0;
        sync_2  <= 1'b0;
        db_cnt  <= '0;
        level   <= 1'b0;
        level_q <= 1'b0;
        evt_r   <= 1'b0;
      end else begin
        sync_1 <= btn_raw[i];
        sync_2 <= sync_1;
        if (sync_2 != level) begin
          if (db_cnt == DB_LAST) begin
            level  <= sync_2;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end else begin
          // any agreement gap restarts the stability count
          db_cnt <= '0;
        end
        level_q <= level;
        evt_r   <= level & ~level_q;
      end
    end

    assign evt[i] = evt_r;
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  state_t      state;
  state_t      state_next;
  logic [63:0] live_cnt;
  logic [63:0] lap_reg;
  logic        ovf;
  logic        counting;
  logic        at_max;
  logic        capture_lap;
  logic        do_clear;

  assign counting = (state == S_RUN) || (state == S_LAP);
  assign at_max   = (live_cnt >= MAX_COUNT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; events that a state ignores do not mask lower-priority ones
  always_comb begin
    state_next  = state;
    capture_lap = 1'b0;
    do_clear    = 1'b0;
    if (counting && at_max) begin
      // saturation forces a pause and swallows any button event this edge
      state_next = S_PAUSE;
    end else begin
      case (state)
        S_IDLE: begin
          if (evt[BTN_SS]) state_next = S_RUN;
        end
        S_RUN: begin
          if (evt[BTN_SS]) begin
            state_next = S_PAUSE;
          end else if (evt[BTN_LAP]) begin
            state_next  = S_LAP;
            capture_lap = 1'b1;
          end
        end
        S_LAP: begin
          if (evt[BTN_SS]) begin
            state_next = S_PAUSE;
          end else if (evt[BTN_LAP]) begin
            state_next = S_RUN;
          end
        end
        S_PAUSE: begin
          if (evt[BTN_CLR]) begin
            state_next = S_IDLE;
            do_clear   = 1'b1;
          end else if (evt[BTN_SS]) begin
            state_next = S_RUN;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Live count, lap capture and sticky overflow
  // --------------------------------------------------------------------------
  // Count on every edge whose pre-edge state is RUN/LAP, saturating at MAX_COUNT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_cnt <= '0;
      lap_reg  <= '0;
      ovf      <= 1'b0;
    end else if (do_clear) begin
      live_cnt <= '0;
      lap_reg  <= '0;
      ovf      <= 1'b0;
    end else begin
      if (counting && !at_max) begin
        live_cnt <= live_cnt + 64'd1;
        if ((live_cnt + 64'd1) == MAX_COUNT) ovf <= 1'b1;
      end
      if (capture_lap) lap_reg <= live_cnt;
    end
  end

  // Outputs are a pure mux/decode of registers
  assign cnt        = (state == S_LAP) ? lap_reg : live_cnt;
  assign running    = counting;
  assign lap_active = (state == S_LAP);
  assign overflow   = ovf;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_counter
//  Description : Self-checking bench for stopwatch_counter (DEBOUNCE_CYCLES=4,
//                MAX_COUNT=100). Stimulus pushes timestamped expectations into
//                a sorted scoreboard; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_counter;

  localparam int unsigned DB   = 4;
  localparam logic [63:0] MAXC = 64'd100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_startstop = 1'b0;
  logic        btn_lap = 1'b0;
  logic        btn_clear = 1'b0;
  logic [63:0] cnt;
  logic        running;
  logic        lap_active;
  logic        overflow;

  stopwatch_counter #(
    .DEBOUNCE_CYCLES(DB),
    .MAX_COUNT      (MAXC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_startstop(btn_startstop),
    .btn_lap      (btn_lap),
    .btn_clear    (btn_clear),
    .cnt          (cnt),
    .running      (running),
    .lap_active   (lap_active),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    string       name;
    logic [63:0] cnt;
    logic        run;
    logic        lap;
    logic        ovf;
    bit          ovf_dc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Insert an expectation for the negedge of cycle 'at', keeping the queue time-ordered
  function automatic void expect_at(int at, string name, logic [63:0] c, logic r,
                                    logic l, logic o, bit odc = 1'b0);
    exp_t e;
    int   i;
    e.at = at; e.name = name; e.cnt = c; e.run = r; e.lap = l; e.ovf = o; e.ovf_dc = odc;
    i = sb.size();
    while (i > 0 && sb[i-1].at > at) i--;
    sb.insert(i, e);
  endfunction

  // Monitor: compare every expectation due this cycle, away from the active edge
  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.at < cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.at, cyc);
      end else if (cnt !== e.cnt || running !== e.run || lap_active !== e.lap ||
                   (!e.ovf_dc && overflow !== e.ovf)) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got cnt=%0d running=%0b lap_active=%0b overflow=%0b, want cnt=%0d running=%0b lap_active=%0b overflow=%0b",
                 e.name, cyc, cnt, running, lap_active, overflow, e.cnt, e.run, e.lap, e.ovf);
      end
    end
  end

  task automatic wait_cyc(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not finish, got time %0t, want < 100000", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int b;

    // Reset held: everything zero
    expect_at(1, "reset_hold", 64'd0, 1'b0, 1'b0, 1'b0);
    expect_at(2, "reset_hold", 64'd0, 1'b0, 1'b0, 1'b0);
    wait_cyc(2);
    rst_n = 1'b1;

    // 1. Quiet after reset
    b = cyc;
    for (int k = 1; k <= 50; k++) expect_at(b + k, "idle_quiet", 64'd0, 1'b0, 1'b0, 1'b0);
    wait_cyc(b + 50);

    // 3. Bouncing startstop (2 high, 2 low) never stays stable for 4 cycles
    b = cyc;
    for (int k = 1; k <= 32; k++) expect_at(b + k, "bounce_idle", 64'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      wait_cyc(b + 2 * i);
      btn_startstop = (i % 2 == 0);
    end
    wait_cyc(b + 20);
    btn_startstop = 1'b0;
    wait_cyc(b + 32);

    // 2. Start: raw first sampled on edge b+1, event high after b+7, RUN from edge b+8
    b = cyc;
    expect_at(b + 7, "start_latency", 64'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) expect_at(b + 8 + k, "run_count", 64'(k), 1'b1, 1'b0, 1'b0);
    // second press at b+20 -> PAUSE on edge b+28, which still counts (20)
    for (int k = 28; k <= 40; k++) expect_at(b + k, "pause_hold", 64'd20, 1'b0, 1'b0, 1'b0);
    btn_startstop = 1'b1;
    wait_cyc(b + 10); btn_startstop = 1'b0;
    wait_cyc(b + 20); btn_startstop = 1'b1;
    wait_cyc(b + 30); btn_startstop = 1'b0;
    wait_cyc(b + 40);

    // 5a. clear + startstop together in PAUSE: clear wins -> IDLE, cnt 0
    b = cyc;
    expect_at(b + 7, "prio_pause_pre", 64'd20, 1'b0, 1'b0, 1'b0);
    for (int k = 8; k <= 20; k++) expect_at(b + k, "prio_pause_clear", 64'd0, 1'b0, 1'b0, 1'b0);
    btn_startstop = 1'b1; btn_clear = 1'b1;
    wait_cyc(b + 10); btn_startstop = 1'b0; btn_clear = 1'b0;
    wait_cyc(b + 20);

    // 4. Lap: capture at edge b+29 (pre-edge count 20), release at edge b+43 (count 35)
    b = cyc;
    for (int k = 0; k <= 20; k++) expect_at(b + 8 + k, "lap_run", 64'(k), 1'b1, 1'b0, 1'b0);
    for (int k = 29; k <= 42; k++) expect_at(b + k, "lap_frozen", 64'd20, 1'b1, 1'b1, 1'b0);
    for (int k = 43; k <= 57; k++) expect_at(b + k, "lap_return", 64'(k - 8), 1'b1, 1'b0, 1'b0);
    // 5b. clear + startstop together in RUN: startstop wins -> PAUSE at edge b+58 (count 50)
    for (int k = 58; k <= 65; k++) expect_at(b + k, "prio_run_pause", 64'd50, 1'b0, 1'b0, 1'b0);
    btn_startstop = 1'b1;
    wait_cyc(b + 10); btn_startstop = 1'b0;
    wait_cyc(b + 21); btn_lap = 1'b1;
    wait_cyc(b + 27); btn_lap = 1'b0;
    wait_cyc(b + 35); btn_lap = 1'b1;
    wait_cyc(b + 41); btn_lap = 1'b0;
    wait_cyc(b + 50); btn_startstop = 1'b1; btn_clear = 1'b1;
    wait_cyc(b + 56); btn_startstop = 1'b0; btn_clear = 1'b0;
    wait_cyc(b + 66);

    // 6. Resume from 50, saturate at 100 on edge b+58, forced PAUSE on b+59, then clear
    b = cyc;
    for (int k = 1; k <= 7; k++) expect_at(b + k, "resume_pre", 64'd50, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 50; k++) expect_at(b + 8 + k, "sat_run", 64'(50 + k), 1'b1, 1'b0, 1'b0);
    expect_at(b + 58, "sat_reach", 64'd100, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 59; k <= 71; k++) expect_at(b + k, "sat_pause", 64'd100, 1'b0, 1'b0, 1'b1);
    for (int k = 72; k <= 78; k++) expect_at(b + k, "sat_clear", 64'd0, 1'b0, 1'b0, 1'b0);
    btn_startstop = 1'b1;
    wait_cyc(b + 6);  btn_startstop = 1'b0;
    wait_cyc(b + 64); btn_clear = 1'b1;
    wait_cyc(b + 70); btn_clear = 1'b0;
    wait_cyc(b + 80);

    // 6. Async reset mid-run with a lap press mid-debounce, then normal restart
    b = cyc;
    for (int k = 1; k <= 7; k++) expect_at(b + k, "rst_pre_idle", 64'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 8; k <= 22; k++) expect_at(b + k, "rst_pre_run", 64'(k - 8), 1'b1, 1'b0, 1'b0);
    for (int k = 23; k <= 37; k++) expect_at(b + k, "rst_async", 64'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 38; k <= 42; k++) expect_at(b + k, "rst_restart", 64'(k - 38), 1'b1, 1'b0, 1'b0);
    btn_startstop = 1'b1;
    wait_cyc(b + 6);  btn_startstop = 1'b0;
    wait_cyc(b + 20); btn_lap = 1'b1;
    wait_cyc(b + 23); rst_n = 1'b0; btn_lap = 1'b0;
    wait_cyc(b + 26); rst_n = 1'b1;
    wait_cyc(b + 30); btn_startstop = 1'b1;
    wait_cyc(b + 36); btn_startstop = 1'b0;
    wait_cyc(b + 44);

    // Anything left unchecked is a failure
    while (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation for cycle %0d never checked, now cycle %0d", sb[0].name, sb[0].at, cyc);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
